// File: rtl/uart_tx_feeder.sv
`default_nettype none
// uart_tx_feeder: byte FIFO that feeds a UART transmitter through a
// three-state launch/handshake FSM. Revision 1.0.
module uart_tx_feeder #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic          busy
);

  localparam int            c_AW        = $clog2(DEPTH);
  localparam logic [CW-1:0] c_DEPTH     = CW'(DEPTH);
  localparam logic [1:0]    c_IDLE      = 2'd0;
  localparam logic [1:0]    c_LAUNCH    = 2'd1;
  localparam logic [1:0]    c_WAIT_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [c_AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q;
  logic [7:0]      txdata_q;
  logic            txdone_q;
  logic [7:0]      mem_q [DEPTH];

  logic w_full, w_empty, w_push, w_pop;

  // Full is judged before any same-cycle pop, so a push at full is always dropped.
  assign w_full  = (count_q == c_DEPTH);
  assign w_empty = (count_q == '0);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = (state_q == c_IDLE) && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= c_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_IDLE:      if (!w_empty) state_d = c_LAUNCH;
      c_LAUNCH:    state_d = c_WAIT_DONE;
      c_WAIT_DONE: if (tx_done && !txdone_q) state_d = c_IDLE;
      default:     state_d = c_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_q == c_LAUNCH);
    busy     = (state_q != c_IDLE);
  end

  always_comb begin
    count_d = count_q;
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= wr_data;
  end

  // txdone_q follows tx_done every cycle, so a level already high when
  // WAIT_DONE is entered never looks like a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      txdata_q <= 8'h00;
      txdone_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf_q    <= wr_en && w_full;
      txdone_q <= tx_done;
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop) begin
        rptr_q   <= rptr_q + 1'b1;
        txdata_q <= mem_q[rptr_q];
      end
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign tx_data  = txdata_q;

endmodule
`default_nettype wire
